// File: rtl/stream_elastic_buffer_pkg.sv
// ============================================================================
// Module : stream_elastic_buffer_pkg
// Brief  : Shared helpers for the elastic buffer (pointer sizing and wrap).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stream_elastic_buffer_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wraps Depth-1 -> 0 so non power-of-two depths index only valid entries.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_elastic_buffer.sv
// ============================================================================
// Module : stream_elastic_buffer
// Brief  : Registered valid/ready stage holding up to DEPTH beats, with flush,
//          occupancy output and an optional pure-wire bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_elastic_buffer
    import stream_elastic_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 2,
    parameter bit          BYPASS      = 1'b0,
    localparam int unsigned USAGE_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [DATA_WIDTH-1:0]  data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [USAGE_WIDTH-1:0] usage_o
);

    if (BYPASS) begin : g_bypass
        logic w_unused;
        assign w_unused = ^{clk_i, rst_ni, flush_i};

        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
        assign usage_o = '0;
    end else begin : g_buffer
        localparam int unsigned c_PTR_WIDTH = ptr_width(DEPTH);

        logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
        logic [c_PTR_WIDTH-1:0] r_wr_ptr;
        logic [c_PTR_WIDTH-1:0] r_rd_ptr;
        logic [USAGE_WIDTH-1:0] r_count;

        logic w_full;
        logic w_empty;
        logic w_push;
        logic w_pop;

        // Full/empty come from the explicit count, never from pointer equality.
        assign w_full  = (r_count == USAGE_WIDTH'(DEPTH));
        assign w_empty = (r_count == '0);

        assign ready_o = ~flush_i & ~w_full;
        assign valid_o = ~flush_i & ~w_empty;
        assign data_o  = r_mem[r_rd_ptr];
        assign usage_o = r_count;

        assign w_push = valid_i & ready_o;
        assign w_pop  = valid_o & ready_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_mem[i] <= '0;
                end
            end else if (flush_i) begin
                // Storage is left untouched; only the bookkeeping is discarded.
                r_count  <= '0;
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= data_i;
                    r_wr_ptr        <= c_PTR_WIDTH'(wrap_inc(32'(r_wr_ptr), DEPTH));
                end
                if (w_pop) begin
                    r_rd_ptr <= c_PTR_WIDTH'(wrap_inc(32'(r_rd_ptr), DEPTH));
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + USAGE_WIDTH'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - USAGE_WIDTH'(1);
                end
            end
        end

`ifndef SYNTHESIS
        a_depth_min: assert property (@(posedge clk_i) DEPTH >= 1);
        a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
            w_push |-> !w_full);
        a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
            w_pop |-> !w_empty);
        a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_o && !ready_i && !flush_i) |=> (flush_i || (valid_o && $stable(data_o))));
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_elastic_buffer.sv
// ============================================================================
// Module : tb_stream_elastic_buffer
// Brief  : Self-checking bench over several depths plus a bypass instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stream_elastic_buffer;

    localparam int NI = 6;

    function automatic int depth_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            4:       return 5;
            default: return 8;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NI-1:0]       vi, ri, fl, vo, ro;
    logic [NI-1:0][7:0]  di, dq;
    logic [NI-1:0][3:0]  us;

    logic       bp_vi, bp_ri, bp_fl, bp_vo, bp_ro;
    logic [7:0] bp_di, bp_dq;
    logic [1:0] bp_us;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = depth_of(g);
        localparam int UW = $clog2(D + 1);
        logic [UW-1:0] w_u;

        stream_elastic_buffer #(
            .DATA_WIDTH (8),
            .DEPTH      (D),
            .BYPASS     (1'b0)
        ) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .flush_i (fl[g]),
            .valid_i (vi[g]),
            .ready_o (ro[g]),
            .data_i  (di[g]),
            .valid_o (vo[g]),
            .ready_i (ri[g]),
            .data_o  (dq[g]),
            .usage_o (w_u)
        );
        assign us[g] = 4'(w_u);
    end

    stream_elastic_buffer #(
        .DATA_WIDTH (8),
        .DEPTH      (2),
        .BYPASS     (1'b1)
    ) u_bypass (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (bp_fl),
        .valid_i (bp_vi),
        .ready_o (bp_ro),
        .data_i  (bp_di),
        .valid_o (bp_vo),
        .ready_i (bp_ri),
        .data_o  (bp_dq),
        .usage_o (bp_us)
    );

    task automatic test_reset;
        @(negedge clk);
        vi = '1; ri = '0; di = {NI{8'hEE}};
        @(negedge clk);
        #1;
        n_checks++;
        if (vo !== '1) begin
            n_fail++; $display("FAIL reset_pre_valid: got %b expected %b", vo, {NI{1'b1}});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (vo !== '0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", vo);
        end
        n_checks++;
        if (ro !== '1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected all ones", ro);
        end
        n_checks++;
        if (us !== '0) begin
            n_fail++; $display("FAIL reset_usage: got %h expected 0", us);
        end
        n_checks++;
        if (dq !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", dq);
        end
        vi = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill;
        int k = 3;
        @(negedge clk);
        ri[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vi[k] = 1'b1; di[k] = 8'(8'hA0 + i);
            @(negedge clk);
        end
        vi[k] = 1'b0;
        #1;
        n_checks++;
        if (us[k] !== 4'd4) begin
            n_fail++; $display("FAIL fill_usage: got %0d expected 4", us[k]);
        end
        n_checks++;
        if (ro[k] !== 1'b0) begin
            n_fail++; $display("FAIL fill_ready: got %b expected 0", ro[k]);
        end
        ri[k] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (vo[k] !== 1'b1 || dq[k] !== 8'(8'hA0 + i)) begin
                n_fail++; $display("FAIL fill_pop_data: got v=%b d=%h expected v=1 d=%h",
                                   vo[k], dq[k], 8'(8'hA0 + i));
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (us[k] !== 4'(3 - i)) begin
                n_fail++; $display("FAIL fill_pop_usage: got %0d expected %0d", us[k], 3 - i);
            end
        end
        ri[k] = 1'b0;
    endtask

    task automatic test_stream(input int k, input int exp_beats, input int step);
        int nbeats = 0;
        @(negedge clk);
        vi[k] = 1'b1; ri[k] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            di[k] = 8'(c);
            #1;
            if (vo[k] && ri[k]) begin
                n_checks++;
                if (dq[k] !== 8'(nbeats * step)) begin
                    n_fail++; $display("FAIL stream_d%0d_order: got %h expected %h",
                                       depth_of(k), dq[k], 8'(nbeats * step));
                end
                nbeats++;
            end
            @(negedge clk);
        end
        vi[k] = 1'b0;
        n_checks++;
        if (nbeats != exp_beats) begin
            n_fail++; $display("FAIL stream_d%0d_count: got %0d expected %0d",
                               depth_of(k), nbeats, exp_beats);
        end
        repeat (3) @(negedge clk);
        ri[k] = 1'b0;
    endtask

    task automatic test_simul;
        int k = 2;
        @(negedge clk);
        ri[k] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vi[k] = 1'b1; di[k] = 8'(10 + i);
            @(negedge clk);
        end
        vi[k] = 1'b0;
        #1;
        n_checks++;
        if (us[k] !== 4'd2) begin
            n_fail++; $display("FAIL simul_prefill: got %0d expected 2", us[k]);
        end
        vi[k] = 1'b1; ri[k] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            di[k] = 8'(12 + c);
            #1;
            n_checks++;
            if (us[k] !== 4'd2 || dq[k] !== 8'(10 + c)) begin
                n_fail++; $display("FAIL simul_pushpop: got u=%0d d=%h expected u=2 d=%h",
                                   us[k], dq[k], 8'(10 + c));
            end
            @(negedge clk);
        end
        vi[k] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (vo[k] !== 1'b1 || dq[k] !== 8'(16 + c)) begin
                n_fail++; $display("FAIL simul_drain: got v=%b d=%h expected v=1 d=%h",
                                   vo[k], dq[k], 8'(16 + c));
            end
            @(negedge clk);
        end
        ri[k] = 1'b0;
    endtask

    task automatic test_flush;
        int k = 4;
        @(negedge clk);
        ri[k] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vi[k] = 1'b1; di[k] = 8'(8'h31 + i);
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (us[k] !== 4'd3) begin
            n_fail++; $display("FAIL flush_prefill: got %0d expected 3", us[k]);
        end
        fl[k] = 1'b1; vi[k] = 1'b1; ri[k] = 1'b1; di[k] = 8'h77;
        #1;
        n_checks++;
        if (vo[k] !== 1'b0 || ro[k] !== 1'b0) begin
            n_fail++; $display("FAIL flush_gate: got v=%b r=%b expected v=0 r=0", vo[k], ro[k]);
        end
        @(negedge clk);
        fl[k] = 1'b0; vi[k] = 1'b0; ri[k] = 1'b0;
        #1;
        n_checks++;
        if (us[k] !== 4'd0 || vo[k] !== 1'b0 || ro[k] !== 1'b1) begin
            n_fail++; $display("FAIL flush_after: got u=%0d v=%b r=%b expected u=0 v=0 r=1",
                               us[k], vo[k], ro[k]);
        end
        vi[k] = 1'b1; di[k] = 8'h55;
        @(negedge clk);
        vi[k] = 1'b0; ri[k] = 1'b1;
        #1;
        n_checks++;
        if (vo[k] !== 1'b1 || dq[k] !== 8'h55) begin
            n_fail++; $display("FAIL flush_first_out: got v=%b d=%h expected v=1 d=55", vo[k], dq[k]);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (us[k] !== 4'd0) begin
            n_fail++; $display("FAIL flush_final_usage: got %0d expected 0", us[k]);
        end
        ri[k] = 1'b0;
    endtask

    task automatic test_bypass;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bp_vi = 1'($urandom); bp_ri = 1'($urandom);
            bp_fl = 1'($urandom); bp_di = 8'($urandom);
            #1;
            n_checks++;
            if (bp_vo !== bp_vi || bp_ro !== bp_ri || bp_dq !== bp_di || bp_us !== 2'd0) begin
                n_fail++; $display("FAIL bypass: got v=%b r=%b d=%h u=%0d expected v=%b r=%b d=%h u=0",
                                   bp_vo, bp_ro, bp_dq, bp_us, bp_vi, bp_ri, bp_di);
            end
        end
    endtask

    task automatic test_random(input int k);
        int         d = depth_of(k);
        logic [7:0] q[$];
        logic       v, r, f, exp_ro, exp_vo;
        logic [7:0] x;
        @(negedge clk);
        fl[k] = 1'b1; vi[k] = 1'b0; ri[k] = 1'b0;
        @(negedge clk);
        fl[k] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 99) < 3);
            x = 8'($urandom);
            vi[k] = v; ri[k] = r; fl[k] = f; di[k] = x;
            #1;
            exp_ro = !f && (q.size() < d);
            exp_vo = !f && (q.size() > 0);
            n_checks++;
            if (ro[k] !== exp_ro) begin
                n_fail++; $display("FAIL rand_d%0d_ready c=%0d: got %b expected %b", d, c, ro[k], exp_ro);
            end
            n_checks++;
            if (vo[k] !== exp_vo) begin
                n_fail++; $display("FAIL rand_d%0d_valid c=%0d: got %b expected %b", d, c, vo[k], exp_vo);
            end
            n_checks++;
            if (us[k] !== 4'(q.size())) begin
                n_fail++; $display("FAIL rand_d%0d_usage c=%0d: got %0d expected %0d", d, c, us[k], q.size());
            end
            if (exp_vo) begin
                n_checks++;
                if (dq[k] !== q[0]) begin
                    n_fail++; $display("FAIL rand_d%0d_data c=%0d: got %h expected %h", d, c, dq[k], q[0]);
                end
            end
            if (f) begin
                q.delete();
            end else begin
                if (exp_vo && r) void'(q.pop_front());
                if (v && exp_ro) q.push_back(x);
            end
            @(negedge clk);
        end
        vi[k] = 1'b0; ri[k] = 1'b0; fl[k] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        vi = '0; ri = '0; fl = '0; di = '0;
        bp_vi = 1'b0; bp_ri = 1'b0; bp_fl = 1'b0; bp_di = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset;
        test_fill;
        test_stream(1, 99, 1);
        test_stream(0, 50, 2);
        test_simul;
        test_flush;
        test_bypass;
        for (int k = 0; k < NI; k++) test_random(k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
